router_ingress_buffer: RTL
==========================

Name: router_ingress_buffer

Overview:
Parametrised ingress staging buffer for the router datapath; the successor of the fixed 5-port, 7-bit, flat-array flit staging pipeline.
- Accepts flits from one shared input bus, steered to a port by a one-hot select, into independent per-port FIFOs.
- Presents each port's head flit to the downstream combinational stage as a tagged output word, under a valid/ready handshake per port.
- Sits between the flit source and the crossbar/route-compute stage.

Parameters:
NPORT, 5, number of ports (0=N, 1=S, 2=E, 3=W, 4=L by convention)
W, 7, input flit width in bits (W >= 2)
DEPTH, 4, entries per port FIFO (power of 2, >= 2)
TAGW, 3, width of the tag field inserted into the output word

Ports:
clk  input  1  rising-edge clock for all state
rst_n  input  1  asynchronous active-low reset
in_data  input  W  flit on the shared input bus
in_sel  input  NPORT  one-hot target port select
in_valid  input  1  source offers in_data
in_ready  output  NPORT-wide OR  1  selected port can accept
out_data  output  NPORT*(W+TAGW)  per-port output word, port p at slice [p*(W+TAGW) +: W+TAGW]
out_valid  output  NPORT  port p head word valid
out_ready  input  NPORT  downstream consumes port p head
err_multi  output  1  sticky: in_valid seen with more than one in_sel bit set

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all FIFOs empty, out_valid=0, out_data=0, err_multi=0, all age counters 0. Reset mid-operation discards all stored flits immediately.
- Port resolution: effective port = lowest set index of in_sel (N beats S beats E, etc.).
  - in_sel==0 means no port; in_ready=0 and nothing is written.
  - in_valid with popcount(in_sel)>1 sets err_multi until reset; the flit still goes to the lowest-index port.
- in_ready: combinational; 1 iff the effective port exists and its FIFO is not full. There is no pass-through on full; a simultaneous pop on a full port does not raise in_ready that cycle.
- Push: in_valid && in_ready at a clock edge writes in_data to the tail of the effective port.
- Latency: a flit pushed into an empty FIFO shows out_valid=1 on the next cycle.
- Pop: out_valid[p] && out_ready[p] at a clock edge removes the head of port p. out_ready on an empty port is ignored.
- Simultaneous push and pop on the same port is legal whenever not full; occupancy is unchanged. Ports are fully independent.
- Pointers wrap modulo DEPTH. Occupancy is tracked with a count of log2(DEPTH)+1 bits; full when count==DEPTH, empty when count==0.
- Output word for port p: {head[W-1], tag, head[W-2:0]}, which keeps the existing 10-bit layout at default widths. When empty, out_data slice = 0 and out_valid=0.
- Output word stability: the word is stable while out_valid && !out_ready; holding the handshake is mandatory.

Optional Feature:
Macro AGE_TAG_EN.
- Defined:
  - Each stored entry carries a TAGW-bit age counter: 0 on write, +1 every cycle the entry remains stored, saturating at 2^TAGW-1.
  - The tag field presents the head entry's current age.
  - With the handshake held, tag may increment while the data bits stay stable.
- Undefined: no age storage; tag = 0 always, and the full output word is stable while held.

Decomposition:
- Package router_pkg:
  - port index constants P_N=0, P_S=1, P_E=2, P_W=3, P_L=4
  - default W/TAGW/DEPTH localparams
  - pack_word function (head, tag -> output word)
  - lowest-set-bit function for in_sel resolution
- Sub-module port_fifo: one per port, holding DEPTH x W data plus optional ages, count, and rd/wr pointers. It has push/pop/full/empty/head/head_age ports and is generated NPORT times.

Test Plan:
- Reset with in_valid=1 and in_sel=5'b00001 held asserted -> after release, out_valid=0, err_multi=0; the first edge with rst_n=1 accepts the flit, and out_valid[0]=1 next cycle.
- Push 7'h45 to S (in_sel=5'b00010) with out_ready=0 -> S slice = 10'b1_000_000101, out_valid=5'b00010.
- Fill E with 4 flits (in_sel=5'b00100, out_ready=0) -> in_ready=0 on the 5th attempt, and that flit is not stored. Then pop all 4 -> values 1,2,3,4 in order, and out_valid[2] drops after the 4th pop.
- in_sel=5'b10010 with in_valid=1 -> flit stored in S only, L empty, err_multi=1 and held through later clean traffic until reset.
- Port W at count=1, push and pop on the same edge, repeated 10 cycles with values 0..9 -> count stays 1, no loss, order preserved.
- AGE_TAG_EN defined, flit held at head of N for 10 cycles -> tag reads 0,1,...,7,7,7 and the data bits stay constant. With the macro undefined, the tag is always 3'b000.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router ingress buffer.
// Port indices, default widths, output word packing and select resolution.
package router_pkg;

  localparam int P_N = 0;
  localparam int P_S = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  localparam int NPORT_D = 5;
  localparam int W_D     = 7;
  localparam int DEPTH_D = 4;
  localparam int TAGW_D  = 3;

  // {head[w-1], tag, head[w-2:0]} built with masks so widths stay generic
  function automatic logic [63:0] pack_word(
    input logic [31:0] head,
    input logic [31:0] tag,
    input int          w,
    input int          tagw
  );
    logic [63:0] lo;
    logic [63:0] msb;
    logic [63:0] tg;
    lo  = {32'b0, head} & ((64'd1 << (w - 1)) - 64'd1);
    msb = ({32'b0, head} >> (w - 1)) & 64'd1;
    tg  = {32'b0, tag} & ((64'd1 << tagw) - 64'd1);
    return lo | (tg << (w - 1)) | (msb << (w - 1 + tagw));
  endfunction

  // Isolate the lowest set bit of a select vector (one-hot or zero)
  function automatic logic [31:0] lowest_set(input logic [31:0] sel);
    return sel & (~sel + 32'd1);
  endfunction

endpackage

// File: rtl/router_ingress_buffer_port_fifo.sv
// Single-port flit FIFO with count-based full/empty tracking.
// AGE_TAG_EN adds a saturating per-entry age counter exposed for the head.
module port_fifo
  import router_pkg::*;
#(
  parameter int W     = W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int TAGW  = TAGW_D
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    wdata,
  output logic            full,
  output logic            empty,
  output logic [W-1:0]    head,
  output logic [TAGW-1:0] head_age
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Flit storage written at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

`ifdef AGE_TAG_EN
  logic [TAGW-1:0] age [DEPTH];

  assign head_age = age[rd_ptr];

  // Ages clear on write and otherwise count up to saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && wr_ptr == AW'(i)) age[i] <= '0;
        else if (age[i] != '1) age[i] <= age[i] + TAGW'(1);
      end
    end
  end
`else
  assign head_age = '0;
`endif

endmodule

// File: rtl/router_ingress_buffer.sv
// Ingress staging buffer: shared input bus steered into per-port FIFOs.
// Optional macro AGE_TAG_EN puts the head entry's age into the tag field.
module router_ingress_buffer
  import router_pkg::*;
#(
  parameter int NPORT = NPORT_D,
  parameter int W     = W_D,
  parameter int DEPTH = DEPTH_D,
  parameter int TAGW  = TAGW_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W-1:0]              in_data,
  input  logic [NPORT-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NPORT*(W+TAGW)-1:0] out_data,
  output logic [NPORT-1:0]          out_valid,
  input  logic [NPORT-1:0]          out_ready,
  output logic                      err_multi
);

  localparam int OW = W + TAGW;

  logic [NPORT-1:0] eff;
  logic [NPORT-1:0] full;
  logic [NPORT-1:0] empty;
  logic [NPORT-1:0] push;
  logic [NPORT-1:0] pop;
  logic             multi;

  assign eff      = NPORT'(lowest_set(32'(in_sel)));
  assign multi    = |(in_sel & (in_sel - NPORT'(1)));
  assign in_ready = |(eff & ~full);
  assign push     = (in_valid && in_ready) ? eff : '0;
  assign pop      = out_ready & ~empty;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [W-1:0]    head;
    logic [TAGW-1:0] head_age;

    port_fifo #(.W(W), .DEPTH(DEPTH), .TAGW(TAGW)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[p]),
      .pop      (pop[p]),
      .wdata    (in_data),
      .full     (full[p]),
      .empty    (empty[p]),
      .head     (head),
      .head_age (head_age)
    );

    assign out_valid[p] = !empty[p];
    assign out_data[p*OW +: OW] = empty[p] ? '0 :
      OW'(pack_word(32'(head), 32'(head_age), W, TAGW));
  end

  // Sticky flag for ambiguous multi-port selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_multi <= 1'b0;
    else if (in_valid && multi) err_multi <= 1'b1;
  end

endmodule
